// File: rtl/cs_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cs_frame_ctrl
//  Description : Frame sequencer for the 9-tap CS smoothing core. On start it
//                clears the core, streams frame_len samples from the sample
//                memory into the core (one per clock, no gaps), and writes one
//                result word per complete WIN-sample window to the result
//                memory.
//  Ports       : clk, reset          - clock, async active-high reset
//                start, frame_len    - frame request + length (IDLE only)
//                abort               - cancel the frame in progress
//                busy, done, err     - status (done is a one-cycle pulse)
//                mem_rd/addr/data    - sample memory (1-cycle read latency)
//                core_clr, x_out     - core clear and sample stream
//                y_in                - core output
//                res_wr/addr/data    - result memory write port
//  Revision    : 1.0 - initial release
// ============================================================================
module cs_frame_ctrl #(
    parameter int ADDR_W = 10,
    parameter int WIN    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] frame_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              core_clr,
    output logic [7:0]        x_out,
    input  logic [9:0]        y_in,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [9:0]        res_data
);

    localparam logic [ADDR_W-1:0] c_WIN    = ADDR_W'(WIN);
    localparam logic [ADDR_W-1:0] c_WIN_M1 = ADDR_W'(WIN - 1);
    localparam logic [ADDR_W-1:0] c_ONE    = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_len, w_len_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic                r_core_clr, w_core_clr_nxt;
    logic                r_mem_rd, w_mem_rd_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic                w_flush;

    // Valid/index pipe following each sample: v1 = data on mem_data,
    // v2 = sample on x_out, v3 = core output for that sample on y_in.
    logic                r_v1, r_v2, r_v3;
    logic [ADDR_W-1:0]   r_idx1, r_idx2, r_idx3;
    logic [7:0]          r_x_out;
    logic                r_res_wr;
    logic [ADDR_W-1:0]   r_res_addr;
    logic [9:0]          r_res_data;
    logic                w_win_full;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_core_clr <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_core_clr <= w_core_clr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state; produces the next value of every registered output
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_core_clr_nxt = 1'b0;
        w_mem_rd_nxt   = 1'b0;
        w_mem_addr_nxt = '0;
        w_flush        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    if (frame_len >= c_WIN) begin
                        w_state_nxt    = S_CLR;
                        w_len_nxt      = frame_len;
                        w_err_nxt      = 1'b0;
                        w_busy_nxt     = 1'b1;
                        w_core_clr_nxt = 1'b1;
                    end else begin
                        // Too short for a single window: reject at once.
                        w_err_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_CLR: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_flush     = 1'b1;
                end else begin
                    w_state_nxt    = S_RUN;
                    w_mem_rd_nxt   = 1'b1;
                    w_mem_addr_nxt = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_flush     = 1'b1;
                end else if (r_mem_addr == r_len - c_ONE) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_mem_rd_nxt   = 1'b1;
                    w_mem_addr_nxt = r_mem_addr + c_ONE;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_flush     = 1'b1;
                end else if (!r_v1 && !r_v2 && !r_v3) begin
                    // Pipe empty: the last result write is on the port now.
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_flush     = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data path: sample in, result out. Only samples at index >= WIN-1
    // close a full window and produce a result write.
    // ------------------------------------------------------------------
    assign w_win_full = r_v3 && (r_idx3 >= c_WIN_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_idx1     <= '0;
            r_idx2     <= '0;
            r_idx3     <= '0;
            r_x_out    <= '0;
            r_res_wr   <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
        end else if (w_flush) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_idx1     <= '0;
            r_idx2     <= '0;
            r_idx3     <= '0;
            r_x_out    <= '0;
            r_res_wr   <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
        end else begin
            r_v1       <= r_mem_rd;
            r_idx1     <= r_mem_addr;
            r_v2       <= r_v1;
            r_idx2     <= r_idx1;
            r_x_out    <= r_v1 ? mem_data : 8'd0;
            r_v3       <= r_v2;
            r_idx3     <= r_idx2;
            r_res_wr   <= w_win_full;
            r_res_addr <= w_win_full ? (r_idx3 - c_WIN_M1) : '0;
            r_res_data <= w_win_full ? y_in : 10'd0;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign core_clr = r_core_clr;
    assign x_out    = r_x_out;
    assign res_wr   = r_res_wr;
    assign res_addr = r_res_addr;
    assign res_data = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_cs_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cs_frame_ctrl
//  Description : Self-checking bench for cs_frame_ctrl with a behavioural
//                sample memory and a 9-tap CS core (window sum >> 2).
//                Expected result writes are queued when a frame is started
//                and matched against the result port as writes appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cs_frame_ctrl;

    localparam int ADDR_W = 10;
    localparam int WIN    = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] frame_len;
    logic              busy, done, err, mem_rd, core_clr, res_wr;
    logic [ADDR_W-1:0] mem_addr, res_addr;
    logic [7:0]        mem_data;
    logic [7:0]        x_out;
    logic [9:0]        y_in;
    logic [9:0]        res_data;

    cs_frame_ctrl #(.ADDR_W(ADDR_W), .WIN(WIN)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .frame_len(frame_len), .busy(busy), .done(done), .err(err),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .core_clr(core_clr), .x_out(x_out), .y_in(y_in),
        .res_wr(res_wr), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample memory: registered read, one cycle latency.
    logic [7:0] smem [0:(1<<ADDR_W)-1];
    initial mem_data = 8'd0;
    always @(posedge clk) if (mem_rd) mem_data <= smem[mem_addr];

    // CS core model: 9-sample window, output = sum >> 2.
    logic [7:0] win [0:WIN-1];
    always @(posedge clk) begin
        if (reset || core_clr) begin
            for (int i = 0; i < WIN; i++) win[i] <= 8'd0;
        end else begin
            win[0] <= x_out;
            for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
        end
    end
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < WIN; i++) s = s + int'(win[i]);
        y_in = 10'(s >> 2);
    end

    logic [43:0] all_outs;
    assign all_outs = {busy, done, err, mem_rd, mem_addr, core_clr, x_out,
                       res_wr, res_addr, res_data};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    typedef struct { int cyc; int addr; int data; } exp_t;
    exp_t exp_q [$];

    // Per-frame statistics collected by the monitor.
    int t0 = 0, cur_len = 0;
    int rd_cnt, wr_cnt, done_cnt, done_cyc, busy_first, busy_last, clr_cnt, clr_cyc;

    always @(negedge clk) begin
        int rel;
        exp_t e;
        rel = cyc - t0;
        if (mem_rd) begin
            chk("mem_addr", mem_addr, rd_cnt);
            chk("mem_rd_cycle", rel, 2 + rd_cnt);
            rd_cnt++;
        end
        if (x_out !== 8'd0) begin
            if (rel >= 4 && rel - 4 < cur_len) chk("x_out", x_out, smem[rel-4]);
            else chk("x_out_idle", x_out, 0);
        end
        if (res_wr) begin
            wr_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL res_wr_unexpected: queue size %0d, want >0 (addr %0d)",
                       exp_q.size(), res_addr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("res_wr_cycle", rel, e.cyc);
                chk("res_addr", res_addr, e.addr);
                chk("res_data", res_data, e.data);
            end
        end
        if (done) begin done_cnt++; done_cyc = rel; end
        if (busy) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
        end
        if (core_clr) begin clr_cnt++; clr_cyc = rel; end
    end

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        busy_first = -1; busy_last = -1; clr_cnt = 0; clr_cyc = -1;
    endtask

    task automatic load_ramp(input int len, input int base, input int step);
        for (int i = 0; i < len; i++) smem[i] = 8'(base + step * i);
    endtask

    task automatic push_expected(input int len);
        for (int j = 0; j + WIN <= len; j++) begin
            exp_t e;
            int s;
            s = 0;
            for (int i = 0; i < WIN; i++) s = s + int'(smem[j+i]);
            e.cyc = 6 + j + (WIN - 1);
            e.addr = j;
            e.data = (s >> 2) & 10'h3ff;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_start(input int len);
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = ADDR_W'(len);
        t0 = cyc;
        cur_len = len;
        clear_stats();
    endtask

    // One frame: abort_at / stray_at are relative cycles (<0 = unused).
    task automatic run_frame(input int len, input int abort_at, input int stray_at);
        if (abort_at < 0) push_expected(len);
        issue_start(len);
        for (int r = 1; r <= len + 12; r++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (r == stray_at) begin start = 1'b1; frame_len = ADDR_W'(5); end
            if (r == abort_at) begin
                abort = 1'b1;
                chk("abort_mem_addr", mem_addr, abort_at - 2);
            end
            if (abort_at >= 0 && r == abort_at + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_mem_rd", mem_rd, 0);
            end
        end
        if (len < WIN) begin
            chk("short_err", err, 1);
            chk("short_done_cnt", done_cnt, 1);
            chk("short_done_cyc", done_cyc, 1);
            chk("short_rd_cnt", rd_cnt, 0);
            chk("short_wr_cnt", wr_cnt, 0);
            chk("short_busy", busy_first, -1);
        end else if (abort_at >= 0) begin
            chk("abort_wr_cnt", wr_cnt, 0);
            chk("abort_done_cnt", done_cnt, 0);
            chk("abort_busy_last", busy_last, abort_at);
            chk("abort_rd_cnt", rd_cnt, abort_at - 1);
        end else begin
            chk("done_cnt", done_cnt, 1);
            chk("done_cyc", done_cyc, len + 6);
            chk("busy_first", busy_first, 1);
            chk("busy_last", busy_last, len + 5);
            chk("rd_cnt", rd_cnt, len);
            chk("wr_cnt", wr_cnt, len - WIN + 1);
            chk("queue_left", exp_q.size(), 0);
            chk("clr_cnt", clr_cnt, 1);
            chk("clr_cyc", clr_cyc, 1);
            chk("err_clear", err, 0);
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; frame_len = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of a 20-sample frame.
        load_ramp(20, 3, 7);
        issue_start(20);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("mid_run_mem_rd", mem_rd, 1);
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", all_outs, 0);
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);

        // Constant frame after reset: 9 x 8 -> one result of 18.
        load_ramp(9, 8, 0);
        run_frame(9, -1, -1);

        // Ramps: exactly-one-window and two-window frames.
        load_ramp(9, 10, 10);
        run_frame(9, -1, -1);
        load_ramp(10, 10, 10);
        run_frame(10, -1, -1);

        // Too-short frames, then a valid frame with a stray start mid-frame.
        run_frame(5, -1, -1);
        run_frame(8, -1, -1);
        load_ramp(9, 10, 10);
        run_frame(9, -1, 5);

        // Abort while mem_addr 6 is on the port, then a clean frame.
        load_ramp(12, 1, 1);
        run_frame(12, 8, -1);
        load_ramp(9, 10, 10);
        run_frame(9, -1, -1);

        // Maximum frame length with random samples.
        for (int i = 0; i < (1 << ADDR_W) - 1; i++) smem[i] = 8'($urandom_range(0, 255));
        run_frame((1 << ADDR_W) - 1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
